// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared definitions for the data-memory controller.
//   - RISC-V load/store funct3 encodings already used by the core (F3_*)
//   - access size encodings (funct3[1:0])
//   - controller FSM state encodings
//   - size_bytes(): access size encoding -> byte count
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // The illegal encoding 3 maps to 4 bytes; it is rejected by decode anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: load/store request/response bus between the core LSU and
// dmem_ctrl.
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_func3            RISC-V funct3
//   req_addr             byte address (ADDR_W bits)
//   req_wdata            store data, right-aligned
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data (0 for stores and errors)
//   rsp_err              access rejected
// modport master: LSU side; modport slave: controller side.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl_array.sv
// dmem_array: DEPTH_WORDS x 32 RAM, synchronous byte-enabled write port and
// registered read port. Contents are never reset.
//   clk    clock, rising edge
//   we     write enable
//   be     per-byte write enables (bit i -> bits 8i+7:8i)
//   waddr  write word address
//   wdata  write data, already in lane position
//   raddr  read word address, sampled on the clock edge
//   rdata  registered read data
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RISC-V data-memory controller. Accepts one load/store at a time,
// splits word-crossing accesses into two word accesses (or rejects them when
// ALLOW_MISALIGNED = 0), rejects out-of-range accesses and illegal funct3,
// and returns little-endian, sign/zero-extended load data.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dmem_ctrl_if slave: request and response handshakes
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS      = 256,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_ctrl_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] BYTES = (ADDR_W+1)'(DEPTH_WORDS * 4);

  function automatic logic [31:0] load_ext(input logic [31:0] b, input logic [2:0] f3);
    case (f3[1:0])
      SZ_BYTE: load_ext = f3[2] ? {24'd0, b[7:0]}  : {{24{b[7]}}, b[7:0]};
      SZ_HALF: load_ext = f3[2] ? {16'd0, b[15:0]} : {{16{b[15]}}, b[15:0]};
      default: load_ext = b;
    endcase
  endfunction

  logic [1:0]  state, state_n;
  logic        ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q, cap_q, cap_n;

  // Decode of the request presented on the bus (used only on acceptance)
  logic [1:0]      sz_in;
  logic [2:0]      nb_in;
  logic [ADDR_W:0] last_in;
  logic            cross_in, err_in, accept;

  assign sz_in    = bus.req_func3[1:0];
  assign nb_in    = size_bytes(sz_in);
  // One extra bit so the last byte address cannot wrap around.
  assign last_in  = {1'b0, bus.req_addr} + (ADDR_W+1)'(nb_in) - (ADDR_W+1)'(1);
  assign cross_in = ({1'b0, bus.req_addr[1:0]} + nb_in) > 3'd4;
  assign err_in   = (sz_in == 2'd3) | (bus.req_write & bus.req_func3[2]) |
                    (last_in >= BYTES) | (cross_in & !ALLOW_MISALIGNED);
  assign accept   = bus.req_valid & ready_q;

  // Stage p0: request fields registered on acceptance
  logic [AW-1:0] word_p0;
  logic [1:0]    off_p0;
  logic [2:0]    f3_p0;
  logic          write_p0, cross_p0;
  logic [31:0]   wdata_p0;

  always_ff @(posedge clk) begin
    if (accept) begin
      word_p0  <= bus.req_addr[AW+1:2];
      off_p0   <= bus.req_addr[1:0];
      f3_p0    <= bus.req_func3;
      write_p0 <= bus.req_write;
      cross_p0 <= cross_in;
      wdata_p0 <= bus.req_wdata;
    end
  end

  // Lane placement over the two-word window {word+1, word}
  logic [2:0]  nb_p0;
  logic [7:0]  be64;
  logic [63:0] wd64;
  logic [4:0]  lo_sh;
  logic [5:0]  hi_sh;

  assign nb_p0 = size_bytes(f3_p0[1:0]);
  assign lo_sh = {off_p0, 3'b000};
  assign hi_sh = 6'd32 - {1'b0, lo_sh};
  assign be64  = ((nb_p0 == 3'd4) ? 8'h0F : (nb_p0 == 3'd2) ? 8'h03 : 8'h01) << off_p0;
  assign wd64  = {32'd0, wdata_p0} << lo_sh;

  // The read port is addressed one state ahead (registered read): the word
  // for ACC0 is requested while accepting in IDLE, the word for ACC1 in ACC0.
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [31:0]   mem_wdata, mem_rdata;

  assign mem_raddr = (state == ST_ACC0) ? word_p0 + AW'(1) : bus.req_addr[AW+1:2];
  assign mem_we    = write_p0 & ((state == ST_ACC0) | (state == ST_ACC1));
  assign mem_waddr = (state == ST_ACC1) ? word_p0 + AW'(1) : word_p0;
  assign mem_be    = (state == ST_ACC1) ? be64[7:4] : be64[3:0];
  assign mem_wdata = (state == ST_ACC1) ? wd64[63:32] : wd64[31:0];

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = err_in ? ST_RESP : ST_ACC0;
      ST_ACC0: state_n = cross_p0 ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_n = ST_RESP;
      default: if (bus.rsp_ready) state_n = ST_IDLE;
    endcase
  end

  // Capture buffer holds the loaded bytes already shifted so byte 0 is addr.
  always_comb begin
    cap_n = cap_q;
    case (state)
      ST_ACC0: cap_n = mem_rdata >> lo_sh;
      ST_ACC1: cap_n = cap_q | (mem_rdata << hi_sh);
      default: cap_n = cap_q;
    endcase
  end

  // Stage p1: response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      cap_q       <= 32'd0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == ST_IDLE);
      cap_q   <= cap_n;
      case (state)
        ST_IDLE: begin
          if (accept && err_in) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (state_n == ST_RESP) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= write_p0 ? 32'd0 : load_ext(cap_n, f3_p0);
          end
        end
        default: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl. Two instances share the clock,
// reset, request fields and rsp_ready: u_dut_m splits word-crossing accesses,
// u_dut_a rejects them. Each has its own req_valid.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v_m, v_a, req_write, rsp_ready;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;

  dmem_ctrl_if #(.ADDR_W(32)) bus_m ();
  dmem_ctrl_if #(.ADDR_W(32)) bus_a ();

  assign bus_m.req_valid = v_m;
  assign bus_m.req_write = req_write;
  assign bus_m.req_func3 = req_func3;
  assign bus_m.req_addr  = req_addr;
  assign bus_m.req_wdata = req_wdata;
  assign bus_m.rsp_ready = rsp_ready;
  assign bus_a.req_valid = v_a;
  assign bus_a.req_write = req_write;
  assign bus_a.req_func3 = req_func3;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.rsp_ready = rsp_ready;

  dmem_ctrl #(.DEPTH_WORDS(256), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );
  dmem_ctrl #(.DEPTH_WORDS(256), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic o_ready(input bit sel);
    return sel ? bus_a.req_ready : bus_m.req_ready;
  endfunction
  function automatic logic o_valid(input bit sel);
    return sel ? bus_a.rsp_valid : bus_m.rsp_valid;
  endfunction
  function automatic logic o_err(input bit sel);
    return sel ? bus_a.rsp_err : bus_m.rsp_err;
  endfunction
  function automatic logic [31:0] o_rdata(input bit sel);
    return sel ? bus_a.rsp_rdata : bus_m.rsp_rdata;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns just after its accept edge.
  task automatic send_req(input bit sel, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_write = wr; req_func3 = f3; req_addr = addr; req_wdata = wd;
    if (sel) v_a = 1'b1; else v_m = 1'b1;
    for (int i = 0; i < 20 && !o_ready(sel); i++) @(negedge clk);
    if (!o_ready(sel)) check("accept_timeout", 32'(o_ready(sel)), 32'd1);
    @(posedge clk);
    #1;
    v_a = 1'b0;
    v_m = 1'b0;
  endtask

  // Counts negedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input bit sel, output logic [31:0] rd, output logic err,
                          output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid(sel) && lat < 20);
    rd  = o_rdata(sel);
    err = o_err(sel);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input bit sel, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input string tag,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        err;
    int          lat;
    send_req(sel, wr, f3, addr, wd);
    wait_rsp(sel, rd, err, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    rst_n = 1'b0; v_m = 1'b0; v_a = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  32'(bus_m.req_ready), 32'd0);
    check("rst_valid",  32'(bus_m.rsp_valid), 32'd0);
    check("rst_err",    32'(bus_m.rsp_err),   32'd0);
    check("rst_rdata",  bus_m.rsp_rdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready_lo", 32'(bus_m.req_ready), 32'd0);
    @(posedge clk);
    #1 check("rel_ready_hi", 32'(bus_m.req_ready), 32'd1);

    // Aligned store/load and extensions
    txn(0, 1'b1, F3_SW,  32'h10, 32'hDEADBEEF, "sw10",  32'h0,        1'b0, 2);
    txn(0, 1'b0, F3_LW,  32'h10, 32'h0,        "lw10",  32'hDEADBEEF, 1'b0, 2);
    txn(0, 1'b0, F3_LB,  32'h13, 32'h0,        "lb13",  32'hFFFFFFDE, 1'b0, 2);
    txn(0, 1'b0, F3_LBU, 32'h13, 32'h0,        "lbu13", 32'h000000DE, 1'b0, 2);
    txn(0, 1'b0, F3_LH,  32'h12, 32'h0,        "lh12",  32'hFFFFDEAD, 1'b0, 2);
    txn(0, 1'b0, F3_LHU, 32'h10, 32'h0,        "lhu10", 32'h0000BEEF, 1'b0, 2);

    // Split store/load
    txn(0, 1'b1, F3_SW,  32'h0E, 32'h11223344, "sw0e",  32'h0,        1'b0, 3);
    txn(0, 1'b0, F3_LBU, 32'h0E, 32'h0,        "b0e",   32'h44,       1'b0, 2);
    txn(0, 1'b0, F3_LBU, 32'h0F, 32'h0,        "b0f",   32'h33,       1'b0, 2);
    txn(0, 1'b0, F3_LBU, 32'h10, 32'h0,        "b10",   32'h22,       1'b0, 2);
    txn(0, 1'b0, F3_LBU, 32'h11, 32'h0,        "b11",   32'h11,       1'b0, 2);
    txn(0, 1'b0, F3_LW,  32'h0E, 32'h0,        "lw0e",  32'h11223344, 1'b0, 3);
    txn(0, 1'b0, F3_LW,  32'h10, 32'h0,        "lw10b", 32'hDEAD1122, 1'b0, 2);
    txn(0, 1'b0, F3_LH,  32'h0F, 32'h0,        "lh0f",  32'h00002233, 1'b0, 3);

    // Range and encoding errors
    txn(0, 1'b1, F3_SB,  32'h400, 32'h5A,      "sb400", 32'h0,        1'b1, 1);
    txn(0, 1'b0, F3_LW,  32'h3FE, 32'h0,       "lw3fe", 32'h0,        1'b1, 1);
    txn(0, 1'b1, F3_SW,  32'h3FC, 32'h55AA0FF0, "sw3fc", 32'h0,       1'b0, 2);
    txn(0, 1'b0, F3_LW,  32'h3FC, 32'h0,       "lw3fc", 32'h55AA0FF0, 1'b0, 2);
    txn(0, 1'b0, F3_LH,  32'h3FE, 32'h0,       "lh3fe", 32'h000055AA, 1'b0, 2);
    txn(0, 1'b0, 3'b011, 32'h0,   32'h0,       "f3_011", 32'h0,       1'b1, 1);
    txn(0, 1'b1, 3'b100, 32'h10,  32'h77,      "sb_f3_4", 32'h0,      1'b1, 1);
    txn(0, 1'b0, F3_LBU, 32'h10,  32'h0,       "b10_kept", 32'h22,    1'b0, 2);

    // Misaligned rejection
    txn(1, 1'b1, F3_SW,  32'h00, 32'hCAFEF00D, "a_sw00", 32'h0,       1'b0, 2);
    txn(1, 1'b0, F3_LH,  32'h03, 32'h0,        "a_lh03", 32'h0,       1'b1, 1);
    txn(1, 1'b1, F3_SH,  32'h03, 32'h0000BEEF, "a_sh03", 32'h0,       1'b1, 1);
    txn(1, 1'b0, F3_LW,  32'h00, 32'h0,        "a_lw00", 32'hCAFEF00D, 1'b0, 2);

    // Backpressure: response held, second request waits
    send_req(0, 1'b0, F3_LW, 32'h10, 32'h0);
    wait_rsp(0, rd, err, lat);
    check("bp_first", rd, 32'hDEAD1122);
    req_write = 1'b0; req_func3 = F3_LBU; req_addr = 32'h0F; req_wdata = 32'h0;
    v_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus_m.rsp_valid), 32'd1);
      check("bp_rdata", bus_m.rsp_rdata,      32'hDEAD1122);
      check("bp_err",   32'(bus_m.rsp_err),   32'd0);
      check("bp_ready", 32'(bus_m.req_ready), 32'd0);
    end
    ack();
    txn(0, 1'b0, F3_LBU, 32'h0F, 32'h0, "bp_next", 32'h33, 1'b0, 2);

    // Reset during ACC1 of a split store
    @(negedge clk);
    req_write = 1'b1; req_func3 = F3_SW; req_addr = 32'h22; req_wdata = 32'hA1B2C3D4;
    v_m = 1'b1;
    check("mid_ready", 32'(bus_m.req_ready), 32'd1);
    @(posedge clk);
    #1 v_m = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus_m.req_ready), 32'd0);
    check("mid_rst_valid", 32'(bus_m.rsp_valid), 32'd0);
    check("mid_rst_err",   32'(bus_m.rsp_err),   32'd0);
    check("mid_rst_rdata", bus_m.rsp_rdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_lo", 32'(bus_m.req_ready), 32'd0);
    @(posedge clk);
    #1 check("mid_rel_hi", 32'(bus_m.req_ready), 32'd1);
    txn(0, 1'b0, F3_LHU, 32'h22, 32'h0, "mid_lhu22", 32'h0000C3D4, 1'b0, 2);
    txn(0, 1'b0, F3_LBU, 32'h23, 32'h0, "mid_lbu23", 32'h000000C3, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised RISC-V data-memory controller between the core's load/store unit and a word-organised byte-enabled RAM. It accepts one load or store per valid/ready request and returns a valid/ready response. Loads are little-endian, with sign or zero extension selected by func3. Accesses that cross a word boundary are either split into two word accesses or rejected with an error, selected by a parameter; out-of-range accesses and illegal func3 values are always rejected.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; byte capacity is DEPTH_WORDS*4.
- `ADDR_W`, 32: request address width.
- `ALLOW_MISALIGNED`, 1: 1 splits word-crossing accesses; 0 returns an error for them.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_func3`  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access rejected.

## Operation
- One transaction is in flight at a time. A request is accepted on a cycle where `req_valid & req_ready`. The request fields are registered on acceptance.
- Decode:
  - Size comes from func3[1:0]: 0 = byte, 1 = half, 2 = word.
  - func3[2] = 1 on a load means zero extension.
- Error conditions (rsp_err = 1):
  - func3[1:0] == 3.
  - A store with func3[2] == 1.
  - addr + size_bytes − 1 ≥ DEPTH_WORDS*4. Addresses do not wrap.
  - A crossing access with ALLOW_MISALIGNED == 0. A crossing access is one where addr[1:0] + size_bytes > 4.
- On error, no memory byte is modified.
- FSM states and transitions:
  - IDLE: req_ready = 1.
    - On accept with an error → RESP.
    - Otherwise → ACC0.
  - ACC0: access word addr>>2.
    - If the access crosses a word boundary → ACC1.
    - Otherwise → RESP.
  - ACC1: access word (addr>>2)+1 → RESP.
  - RESP: rsp_valid = 1. Data and error are held stable until `rsp_ready`, then → IDLE.
- Stores: byte enables are derived from addr[1:0] and size. ACC0 writes the low-word bytes and ACC1 writes the remaining bytes. Write data is rotated into lane position.
- Loads:
  - The word read in each ACC state is captured into a 4-byte buffer.
  - Bytes are assembled starting at addr, byte 0 = lowest address.
  - The result is extended to 32 bits per func3.
- `req_ready` = 0 in ACC0, ACC1 and RESP. Requests presented then are not accepted and must be held by the requester.

## Timing
- Take the accept edge as cycle T.
  - Error response: rsp_valid at T+1.
  - Aligned access: rsp_valid at T+2.
  - Split access: rsp_valid at T+3.
- The RESP → IDLE handshake edge returns req_ready = 1 in the next cycle. Best-case aligned throughput is one access per 3 cycles.
- The array has a synchronous write and a registered read. Data addressed in ACCn is available to the buffer at the end of ACCn.
- Reset values, applied asynchronously while rst_n = 0:
  - state = IDLE.
  - req_ready = 0, rising to 1 on the first clock after release.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - The capture buffer is cleared.
- Memory contents are not reset. If reset lands mid-split store, any low-word bytes already written remain, and no rollback is performed.
- rsp_ready high while not in RESP has no effect.

## Structure
- Shared defines file holds:
  - the F3_* load/store constants already used by the core;
  - the size encodings;
  - the FSM state localparams.
- Sub-module `dmem_array`: DEPTH_WORDS×32 RAM with 4-bit byte-enable write and registered read. The controller holds the FSM, decode, lane rotation and extension.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → rdata 0xDEADBEEF, rsp_err 0, rsp_valid at T+2 for both.
- After the above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- ALLOW_MISALIGNED=1:
  - SW 0x11223344 @0x0E → bytes 0x0E=44, 0x0F=33, 0x10=22, 0x11=11.
  - LW @0x0E → 0x11223344 at T+3.
- ALLOW_MISALIGNED=0: LH @0x03 → rsp_err 1 at T+1, rdata 0. A following LW @0x00 shows the word unchanged.
- DEPTH_WORDS=256:
  - SB @0x400 → err.
  - LW @0x3FE → err.
  - func3=3'b011 → err.
  - SB with func3=3'b100 → err, no write.
- Backpressure and reset:
  - With rsp_ready low for 5 cycles, the response stays stable and req_ready stays 0 while req_valid is held.
  - rst_n pulled low during ACC1 of a split store → outputs go to reset values immediately. After release, req_ready = 1 on the next cycle, and the low-word bytes read back as written.
